// File: rtl/serial_subtract.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock,
// built from a single full-subtract cell made of two half subtractors.

module half_subtract (
   input  logic x_i,
   input  logic y_i,
   output logic d_o,
   output logic b_o
);
   assign d_o = x_i ^ y_i;
   assign b_o = ~x_i & y_i;
endmodule

// state | meaning
// IDLE  | waiting for start; diff/bout hold the last result
// RUN   | one operand bit pair consumed per edge, WIDTH edges total
// DONE  | single-cycle done pulse, then back to IDLE
module serial_subtract #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic             bout_q;
   logic             busy_q;
   logic             done_q;
   logic [CW-1:0]    cnt_q;

   logic d1_d, b1_d, d_d, b2_d, borrow_d;

   half_subtract u_hs0 (
      .x_i (a_sh_q[0]),
      .y_i (b_sh_q[0]),
      .d_o (d1_d),
      .b_o (b1_d)
   );

   half_subtract u_hs1 (
      .x_i (d1_d),
      .y_i (borrow_q),
      .d_o (d_d),
      .b_o (b2_d)
   );

   assign borrow_d = b1_d | b2_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // diff/bout are left alone so the previous result stays readable
               if (start_i) begin
                  a_sh_q   <= a_i;
                  b_sh_q   <= b_i;
                  borrow_q <= 1'b0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               diff_q   <= {d_d, diff_q[WIDTH-1:1]};
               borrow_q <= borrow_d;
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  bout_q  <= borrow_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign diff_o = diff_q;
   assign bout_o = bout_q;
endmodule

// File: tb/tb_serial_subtract.sv
// Directed bench for serial_subtract: vector table at WIDTH=8, corner-case
// sequences (restart while busy, reset mid-run, back-to-back), exhaustive WIDTH=4.

module tb_serial_subtract;
   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start4;
   logic [7:0] a8, b8, diff8;
   logic [3:0] a4, b4, diff4;
   logic       busy8, done8, bout8, busy4, done4, bout4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_subtract #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
      .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8)
   );

   serial_subtract #(.WIDTH(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4),
      .busy_o(busy4), .done_o(done4), .diff_o(diff4), .bout_o(bout4)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   vec_t vecs[10];
   vec_t bb[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Caller is at a negedge. Issues one start pulse, then watches 30 cycles.
   // lat counts edges from the accepting edge (inclusive) to the done cycle.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] d, output logic bo,
                      output int lat, output int nbusy, output int ndone, output int nx);
      start8 = 1'b1; a8 = a; b8 = b;
      @(negedge clk);
      start8 = 1'b0; a8 = ~a; b8 = ~b;
      lat = -1; nbusy = 0; ndone = 0; nx = 0; d = '0; bo = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (busy8) nbusy++;
         if ($isunknown(diff8)) nx++;
         if (done8) begin
            ndone++;
            if (lat < 0) begin
               lat = i + 1; d = diff8; bo = bout8;
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       bo;
      int         lat, nbusy, ndone, nx, last_done, k;
      logic       prev_busy, got;
      logic [8:0] expq[$];
      logic [8:0] e;

      vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
      vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{8'hA5, 8'h3C, 8'h69, 1'b0};
      vecs[5] = '{8'h10, 8'h01, 8'h0F, 1'b0};
      vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
      vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0};
      vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
      vecs[9] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

      bb[0] = '{8'h12, 8'h34, 8'hDE, 1'b1};
      bb[1] = '{8'hF0, 8'h0F, 8'hE1, 1'b0};
      bb[2] = '{8'h01, 8'h02, 8'hFF, 1'b1};
      bb[3] = '{8'h80, 8'h80, 8'h00, 1'b0};
      bb[4] = '{8'h00, 8'h00, 8'h00, 1'b0};

      rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      #2;
      chk("reset_busy", 32'(busy8), 0);
      chk("reset_done", 32'(done8), 0);
      chk("reset_diff", 32'(diff8), 0);
      chk("reset_bout", 32'(bout8), 0);
      chk("reset_w4", {busy4, done4, diff4, bout4}, 0);

      // Start presented in the same cycle reset is released.
      @(negedge clk);
      rst = 1'b0;
      foreach (vecs[i]) begin
         op8(vecs[i].a, vecs[i].b, d, bo, lat, nbusy, ndone, nx);
         chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].d));
         chk($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].bo));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 9);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), 9);
         chk($sformatf("vec%0d_done_pulses", i), 32'(ndone), 1);
         chk($sformatf("vec%0d_diff_x", i), 32'(nx), 0);
         chk($sformatf("vec%0d_diff_hold", i), 32'(diff8), 32'(vecs[i].d));
      end

      // Restart attempt while running must be ignored.
      start8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
      @(negedge clk);
      start8 = 1'b0;
      ndone = 0; d = '0; bo = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (done8) begin
            ndone++; d = diff8; bo = bout8;
         end
         @(negedge clk);
      end
      chk("restart_diff", 32'(d), 32'h69);
      chk("restart_bout", 32'(bo), 0);
      chk("restart_done_pulses", 32'(ndone), 1);
      chk("restart_idle", 32'(busy8), 0);

      // Reset four cycles into RUN, held for two cycles.
      start8 = 1'b1; a8 = 8'h55; b8 = 8'h0F;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", 32'(busy8), 1);
      rst = 1'b1;
      #1;
      chk("abort_outputs", {busy8, done8, diff8, bout8}, 0);
      ndone = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      chk("abort_outputs_held", {busy8, done8, diff8, bout8}, 0);
      chk("abort_no_done", 32'(ndone), 0);
      rst = 1'b0;
      op8(8'h10, 8'h01, d, bo, lat, nbusy, ndone, nx);
      chk("post_abort_diff", 32'(d), 32'h0F);
      chk("post_abort_bout", 32'(bo), 0);
      chk("post_abort_latency", 32'(lat), 9);
      chk("post_abort_done_pulses", 32'(ndone), 1);

      // Start held high: one result every 10 cycles.
      k = 0; last_done = -1; ndone = 0; prev_busy = 1'b0;
      start8 = 1'b1; a8 = bb[0].a; b8 = bb[0].b;
      for (int c = 0; c < 80 && ndone < 4; c++) begin
         @(negedge clk);
         if (busy8 && !prev_busy) begin
            expq.push_back({bb[k].d, bb[k].bo});
            k++;
            a8 = bb[k].a; b8 = bb[k].b;
         end
         if (done8) begin
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk($sformatf("b2b%0d_result", ndone), {diff8, bout8}, 32'(e));
            end else begin
               chk($sformatf("b2b%0d_unexpected_done", ndone), 1, 0);
            end
            if (last_done >= 0) chk($sformatf("b2b%0d_interval", ndone), 32'(c - last_done), 10);
            last_done = c;
            ndone++;
            if (ndone == 4) start8 = 1'b0;
         end
         prev_busy = busy8;
      end
      chk("b2b_done_count", 32'(ndone), 4);

      // Exhaustive WIDTH=4 against the arithmetic reference.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            start4 = 1'b1; a4 = 4'(a); b4 = 4'(b);
            @(negedge clk);
            start4 = 1'b0; a4 = ~a4;
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
               if (done4) got = 1'b1;
               else @(negedge clk);
            end
            if (got) chk($sformatf("w4_%0d_minus_%0d", a, b), {diff4, bout4}, {4'(a - b), 1'(a < b)});
            else chk($sformatf("w4_%0d_minus_%0d_timeout", a, b), 0, 1);
            @(negedge clk);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/serial_subtract.md
SERIAL_SUBTRACT -- requirements
Module: serial_subtract

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin one subtraction; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  minuend; sampled with start.
REQ-006 b  input  WIDTH  subtrahend; sampled with start.
REQ-007 busy  output  1  high while an operation is in progress (states RUN and DONE).
REQ-008 done  output  1  one-cycle pulse marking diff/bout valid.
REQ-009 diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 bout  output  1  final borrow: 1 when a < b, unsigned.

Function
REQ-011 The block SHALL compute a-b bit-serially, LSB first, one bit per clk cycle, with a single 1-bit full-subtract cell.
REQ-012 The full-subtract cell SHALL be two half_subtract instances plus one OR gate: (x, y) -> d1/b1, then (d1, borrow_reg) -> d/b2, with borrow_next = b1 | b2.
REQ-013 FSM states SHALL be IDLE, RUN and DONE, binary encoded, with IDLE as the reset state.
REQ-014 IDLE: start=1 at an edge SHALL load shift registers with a and b, clear borrow_reg, clear bit counter, and go to RUN; start=0 stays in IDLE.
REQ-015 RUN: each edge SHALL shift the cell's d into the diff shift register (MSB in, shift right), update borrow_reg, shift both operand registers right by 1, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; the edge processing bit WIDTH-1 SHALL move to DONE and register bout = borrow_next.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency SHALL be fixed: done high in the cycle beginning WIDTH+1 edges after the edge that sampled start.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 done SHALL be a registered output, equal to (state==DONE), never combinational from inputs.
REQ-021 diff and bout SHALL stay stable from DONE until the next accepted start plus one edge, so they remain readable in IDLE.
REQ-022 diff SHALL be undefined-free during RUN: it may show partial shift contents, but never X after reset.
REQ-023 start while busy=1 (RUN or DONE) SHALL be ignored, with no effect on the operation or on operands.
REQ-024 a and b changing after the accepting edge SHALL have no effect on the result.
REQ-025 Back-to-back use: start high in the first IDLE cycle after DONE SHALL be accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-026 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, diff=0, bout=0, borrow_reg=0, counter=0 and operand registers=0, regardless of clk.
REQ-028 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be handled normally.
REQ-029 start sampled on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-030 WIDTH=8, a=0x05, b=0x03, start for 1 cycle -> done pulse 9 edges later, diff=0x02, bout=0, busy high for 9 cycles.
REQ-031 a=0x03, b=0x05 -> diff=0xFE, bout=1; a=0x00, b=0x01 -> diff=0xFF, bout=1; a=0x00, b=0x00 -> diff=0x00, bout=0.
REQ-032 a=0xA5, b=0x3C started; start re-pulsed with a=0xFF, b=0x00 during RUN -> result is still diff=0x69, bout=0, with exactly one done pulse.
REQ-033 rst asserted 4 cycles into RUN, held 2 cycles -> all outputs 0 with no done pulse; then a=0x10, b=0x01 -> diff=0x0F, bout=0.
REQ-034 Back-to-back: start held high continuously -> done every 10 cycles, and each result matches operands sampled at its accepting edge.
REQ-035 Exhaustive WIDTH=4: all 256 (a, b) pairs checked against the reference model diff=(a-b) mod 16, bout=(a<b).
